// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
package regfile_wb_ctrl_pkg;

  localparam int REG_W    = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // One writeback request as seen by the write port.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [REG_W-1:0]  data;
  } wb_req_t;

  // Which requester won the most recent grant.
  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } arb_last_e;

  // One-hot mask selecting a single register of the scoreboard.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [ADDR_W-1:0] addr);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin arbiter between the ALU and load-unit writeback requests.
module wb_rr_arb2
  import regfile_wb_ctrl_pkg::*;
#(
  parameter logic ALU_FIRST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic grant_alu,
  output logic grant_mem
);

  // Pretending the other side went last makes the preferred side win first.
  localparam arb_last_e LAST_INIT = ALU_FIRST ? LAST_MEM : LAST_ALU;

  arb_last_e last_r;
  arb_last_e last_nxt_s;

  // Arbiter state register; holds whichever side was granted most recently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_r <= LAST_INIT;
    end else begin
      last_r <= last_nxt_s;
    end
  end

  // Grant decode and next-state: a lone requester wins, a contest goes to the side not granted last.
  always_comb begin
    grant_alu  = 1'b0;
    grant_mem  = 1'b0;
    last_nxt_s = last_r;
    case ({alu_valid, mem_valid})
      2'b10: grant_alu = 1'b1;
      2'b01: grant_mem = 1'b1;
      2'b11: begin
        if (last_r == LAST_MEM) begin
          grant_alu = 1'b1;
        end else begin
          grant_mem = 1'b1;
        end
      end
      default: begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
      end
    endcase
    if (grant_alu) begin
      last_nxt_s = LAST_ALU;
    end else if (grant_mem) begin
      last_nxt_s = LAST_MEM;
    end else begin
      last_nxt_s = last_r;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU/load writebacks onto the register file
// write port and tracks in-flight destinations to stall dependent issues.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter logic ZERO_REG  = 1'b1,
  parameter logic ALU_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [REG_W-1:0]  alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [REG_W-1:0]  mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              rs1_en,
  input  logic              rs2_en,
  output logic              stall,
  output logic [REG_W-1:0]  Dc,
  output logic              write,
  output logic [ADDR_W-1:0] rd,
  output logic              wb_err
);

  logic                grant_alu_s;
  logic                grant_mem_s;
  logic                hs_s;
  logic                drop_s;
  logic                stall_s;
  logic                issue_set_s;
  wb_req_t             sel_req_s;
  logic                write_r;
  logic [ADDR_W-1:0]   rd_r;
  logic [REG_W-1:0]    dc_r;
  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pending_nxt_s;
  logic                wb_err_r;

  wb_rr_arb2 #(
    .ALU_FIRST (ALU_FIRST)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .grant_alu (grant_alu_s),
    .grant_mem (grant_mem_s)
  );

  // Select the granted request and decide whether it targets the hardwired zero register.
  always_comb begin
    sel_req_s = '0;
    if (grant_alu_s) begin
      sel_req_s.rd   = alu_rd;
      sel_req_s.data = alu_data;
    end else if (grant_mem_s) begin
      sel_req_s.rd   = mem_rd;
      sel_req_s.data = mem_data;
    end else begin
      sel_req_s = '0;
    end
    hs_s        = (alu_valid && grant_alu_s) || (mem_valid && grant_mem_s);
    drop_s      = ZERO_REG && (sel_req_s.rd == {ADDR_W{1'b0}});
    stall_s     = (rs1_en && pending_r[rs1]) || (rs2_en && pending_r[rs2]);
    issue_set_s = issue_valid && !stall_s && !(ZERO_REG && (issue_rd == {ADDR_W{1'b0}}));
  end

  // Scoreboard next state: the landing write clears its bit, a new issue sets its bit and wins ties.
  always_comb begin
    pending_nxt_s = pending_r;
    if (write_r) begin
      pending_nxt_s = pending_nxt_s & ~reg_mask(rd_r);
    end else begin
      pending_nxt_s = pending_r;
    end
    if (issue_set_s) begin
      pending_nxt_s = pending_nxt_s | reg_mask(issue_rd);
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Write-port output stage: capture the accepted request, pulse write for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_r <= 1'b0;
      rd_r    <= {ADDR_W{1'b0}};
      dc_r    <= {REG_W{1'b0}};
    end else if (hs_s) begin
      write_r <= !drop_s;
      rd_r    <= sel_req_s.rd;
      dc_r    <= sel_req_s.data;
    end else begin
      write_r <= 1'b0;
    end
  end

  // Scoreboard register plus sticky flag for a write landing on a register nobody was waiting for.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= {NUM_REGS{1'b0}};
      wb_err_r  <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      if (write_r && !pending_r[rd_r]) begin
        wb_err_r <= 1'b1;
      end
    end
  end

  assign alu_ready = grant_alu_s;
  assign mem_ready = grant_mem_s;
  assign stall     = stall_s;
  assign write     = write_r;
  assign rd        = rd_r;
  assign Dc        = dc_r;
  assign wb_err    = wb_err_r;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the writeback/scoreboard rules.
module tb_regfile_wb_ctrl;

  localparam bit TB_ZERO_REG  = 1'b1;
  localparam bit TB_ALU_FIRST = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid, rs1_en, rs2_en;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, stall, write, wb_err;
  logic [4:0]  rd;
  logic [31:0] Dc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_pend [32];
  bit          m_write;
  logic [4:0]  m_rd;
  logic [31:0] m_dc;
  bit          m_err;
  bit          m_alu_wins;
  bit          g_alu_last, g_mem_last;

  regfile_wb_ctrl #(
    .ZERO_REG  (TB_ZERO_REG),
    .ALU_FIRST (TB_ALU_FIRST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_en      (rs1_en),
    .rs2_en      (rs2_en),
    .stall       (stall),
    .Dc          (Dc),
    .write       (write),
    .rd          (rd),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_write    = 1'b0;
    m_rd       = 5'd0;
    m_dc       = 32'd0;
    m_err      = 1'b0;
    m_alu_wins = TB_ALU_FIRST;
    g_alu_last = 1'b0;
    g_mem_last = 1'b0;
  endtask

  // Called right after a negedge with inputs driven; advances one clock.
  task automatic cycle();
    bit ga, gm, st;
    #1;
    ga = alu_valid && (!mem_valid || m_alu_wins);
    gm = mem_valid && (!alu_valid || !m_alu_wins);
    st = (rs1_en && m_pend[rs1]) || (rs2_en && m_pend[rs2]);
    check_eq("alu_ready", 32'(alu_ready), 32'(ga));
    check_eq("mem_ready", 32'(mem_ready), 32'(gm));
    check_eq("stall", 32'(stall), 32'(st));
    @(posedge clk);
    if (m_write && !m_pend[m_rd]) m_err = 1'b1;
    if (m_write) m_pend[m_rd] = 1'b0;
    if (issue_valid && !st && !(TB_ZERO_REG && issue_rd == 5'd0)) m_pend[issue_rd] = 1'b1;
    if (ga) begin
      m_write = !(TB_ZERO_REG && alu_rd == 5'd0);
      m_rd = alu_rd; m_dc = alu_data; m_alu_wins = 1'b0;
    end else if (gm) begin
      m_write = !(TB_ZERO_REG && mem_rd == 5'd0);
      m_rd = mem_rd; m_dc = mem_data; m_alu_wins = 1'b1;
    end else begin
      m_write = 1'b0;
    end
    g_alu_last = ga;
    g_mem_last = gm;
    @(negedge clk);
    check_eq("write", 32'(write), 32'(m_write));
    check_eq("rd", 32'(rd), 32'(m_rd));
    check_eq("Dc", Dc, m_dc);
    check_eq("wb_err", 32'(wb_err), 32'(m_err));
  endtask

  // Asynchronous reset pulse starting between edges; rs fields are left as the caller set them.
  task automatic apply_reset();
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_wb_err", 32'(wb_err), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_rd", 32'(rd), 32'd0);
    check_eq("rst_Dc", Dc, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    rs1_en = 1'b0; rs2_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    alu_rd = 5'd0; mem_rd = 5'd0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    rs1_en = 1'b0; rs2_en = 1'b0; alu_data = 32'd0; mem_data = 32'd0;
    model_reset();
    @(negedge clk);
    check_eq("init_write", 32'(write), 32'd0);
    check_eq("init_wb_err", 32'(wb_err), 32'd0);
    check_eq("init_rd", 32'(rd), 32'd0);
    reset = 1'b1;

    // Issue rd=5, dependent read stalls until the ALU write lands.
    issue_valid = 1'b1; issue_rd = 5'd5;
    cycle();
    issue_valid = 1'b0; rs1 = 5'd5; rs1_en = 1'b1;
    cycle();
    check_eq("t1_stall_pending", 32'(stall), 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    check_eq("t1_write", 32'(write), 32'd1);
    check_eq("t1_rd", 32'(rd), 32'd5);
    check_eq("t1_Dc", Dc, 32'hDEADBEEF);
    alu_valid = 1'b0;
    cycle();
    check_eq("t1_stall_clear", 32'(stall), 32'd0);
    check_eq("t1_no_err", 32'(wb_err), 32'd0);

    // Contested requests alternate starting with the ALU.
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0A03;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0B04;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("t2_rd_seq", 32'(rd), (i % 2 == 1) ? 32'd4 : 32'd3);
      check_eq("t2_write", 32'(write), 32'd1);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle();

    // Register 0 is never pending and its writes are discarded.
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0; rs1_en = 1'b1;
    cycle();
    issue_valid = 1'b0;
    cycle();
    check_eq("t3_stall_r0", 32'(stall), 32'd0);
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234_5678;
    #1 check_eq("t3_mem_ready", 32'(mem_ready), 32'd1);
    cycle();
    check_eq("t3_write_r0", 32'(write), 32'd0);
    mem_valid = 1'b0;
    cycle();
    check_eq("t3_no_err", 32'(wb_err), 32'd0);

    // Issue and write of the same register on one edge: set wins.
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_0007;
    cycle();
    alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    issue_valid = 1'b0; rs2 = 5'd7; rs2_en = 1'b1;
    #1 check_eq("t4_stall_rs2", 32'(stall), 32'd1);
    cycle();

    // Write to a non-pending register raises a sticky error.
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0009;
    cycle();
    alu_valid = 1'b0;
    cycle();
    check_eq("t5_err_set", 32'(wb_err), 32'd1);
    repeat (3) cycle();
    check_eq("t5_err_sticky", 32'(wb_err), 32'd1);

    // Reset while a write is in flight, then ALU wins the first contest.
    issue_valid = 1'b1; issue_rd = 5'd2;
    cycle();
    issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hCAFE_0002;
    cycle();
    check_eq("t6_write_inflight", 32'(write), 32'd1);
    rs1 = 5'd2; rs1_en = 1'b1;
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h0000_0011;
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h0000_0012;
    #1 check_eq("t6_alu_first", 32'(alu_ready), 32'd1);
    cycle();
    check_eq("t6_rd_alu", 32'(rd), 32'd11);
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle();

    // Random traffic with requesters holding their request until accepted.
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset();
      end else begin
        if (!alu_valid || g_alu_last) begin
          alu_valid = 1'($urandom_range(0, 1));
          alu_rd    = 5'($urandom_range(0, 7));
          alu_data  = $urandom;
        end
        if (!mem_valid || g_mem_last) begin
          mem_valid = 1'($urandom_range(0, 1));
          mem_rd    = 5'($urandom_range(0, 7));
          mem_data  = $urandom;
        end
        issue_valid = 1'($urandom_range(0, 1));
        issue_rd    = 5'($urandom_range(0, 7));
        rs1         = 5'($urandom_range(0, 7));
        rs2         = 5'($urandom_range(0, 7));
        rs1_en      = 1'($urandom_range(0, 1));
        rs2_en      = 1'($urandom_range(0, 1));
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Writeback controller for the 32x32 register file. It arbitrates two writeback requesters, the ALU and the load unit, onto the file's single write port (`Dc`/`write`/`rd`) using round-robin with valid/ready handshakes. It keeps a 32-bit pending scoreboard and raises `stall` when an issuing instruction reads a register whose write has not yet landed. It sits between the execute/memory stages and the register file's write port.

## Interface
- `ZERO_REG`, default 1: when 1, register 0 is read-only. Writes to rd=0 are accepted and discarded, and issues to rd=0 never set pending.
- `ALU_FIRST`, default 1: side that wins the first contested cycle after reset (1 = ALU).
- `clk` in 1: the single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `alu_valid` in 1: ALU writeback request.
- `alu_rd` in 5: ALU destination.
- `alu_data` in 32: ALU result.
- `alu_ready` out 1: grant to ALU (combinational).
- `mem_valid` in 1: load writeback request.
- `mem_rd` in 5: load destination.
- `mem_data` in 32: load result.
- `mem_ready` out 1: grant to load unit (combinational).
- `issue_valid` in 1: an instruction issues this cycle.
- `issue_rd` in 5: its destination; marked pending.
- `rs1`, `rs2` in 5 each: source registers of the issuing instruction.
- `rs1_en`, `rs2_en` in 1 each: the corresponding source is used.
- `stall` out 1: issue must hold (combinational).
- `Dc` out 32: write data to the register file (registered).
- `write` out 1: write enable to the register file (registered).
- `rd` out 5: write address to the register file (registered).
- `wb_err` out 1: sticky flag; a write completed to a register that was not pending.

## Operation
- Arbiter state is the one-bit `last`, with states LAST_ALU and LAST_MEM. Its reset state is LAST_MEM if ALU_FIRST=1, otherwise LAST_ALU.
- Only one requester valid: that requester is granted.
- Both valid: the side not equal to `last` is granted.
- On a grant, `last` moves to the granted side. When there is no grant, `last` holds.
- `alu_ready` = grant_alu and `mem_ready` = grant_mem; at most one is high. The handshake completes on a posedge where valid and ready are both high.
- Output stage, on a handshake:
  - `rd` and `Dc` load the granted request.
  - `write` is set to 1, except that it is set to 0 when ZERO_REG=1 and the rd is 0.
- With no handshake, `write` goes to 0 and `rd`/`Dc` hold.
- Scoreboard `pending[31:0]`:
  - Set bit `issue_rd` on a posedge with `issue_valid` high and `stall` low.
  - Clear bit `rd` on a posedge with `write` high.
  - When set and clear hit the same bit on the same edge, set wins.
  - pending[0] is never set when ZERO_REG=1.
- `stall` = (`rs1_en` and pending[`rs1`]) or (`rs2_en` and pending[`rs2`]). `issue_rd` itself does not stall (WAW is allowed; the later issue re-sets the bit).
- `wb_err` sets on a posedge where `write` is high and pending[`rd`] is low (before any set on that edge). It clears only on reset.

## Timing
- Reset values: `write`=0, `rd`=0, `Dc`=0, `pending`=0, `wb_err`=0, `last` per ALU_FIRST.
- Handshake at edge N: `write`/`rd`/`Dc` are valid in cycle N..N+1. The register file captures at edge N+1, and pending[rd] clears at edge N+1. From cycle N+1 on, `stall` is low for that register and a read returns the new value.
- Maximum throughput is one writeback per cycle. With both requesters held valid, grants strictly alternate.
- Requesters must hold `rd`/`data` stable while valid and not ready.
- An asynchronous reset asserted mid-transfer drops any in-flight write (`write` is 0 immediately). The lost write is not replayed.

## Structure
- A shared package holds:
  - `REG_W`=32 and `ADDR_W`=5.
  - The typedef `wb_req_t {rd, data}`.
  - The arbiter state enum `{LAST_ALU, LAST_MEM}`.
- One sub-module, `wb_rr_arb2`, is the two-way round-robin arbiter holding `last` and producing the grants. Scoreboard and output stage stay in the top level.

## Test plan
- Reset, then issue rd=5 → pending[5]=1; with rs1=5 and rs1_en=1, `stall`=1. Then ALU writes rd=5 data 0xDEADBEEF → `write`=1, `rd`=5, `Dc`=0xDEADBEEF one edge later; `stall`=0 the cycle after; no `wb_err`.
- ALU (rd=3) and mem (rd=4) both valid for 4 cycles, ALU_FIRST=1 → grant order ALU, MEM, ALU, MEM. `rd` sequence 3,4,3,4 with `write` high each cycle.
- ZERO_REG=1: issue rd=0 → pending stays 0. mem writes rd=0 → `mem_ready`=1, `write` stays 0, `wb_err`=0.
- Same edge: `write` high with `rd`=7, and issue rd=7 → pending[7]=1 afterwards; `stall` for rs2=7 with rs2_en=1 is 1.
- ALU writes rd=9 with pending[9]=0 → `wb_err`=1 and it stays 1 until `reset` goes low.
- Drop `reset` while `write`=1 → `write`, pending, and `wb_err` read 0 before the next clock edge. After release, the arbiter grants ALU first when contested.
